// File: rtl/sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment
// display. One digit is selected per slot: its nibble goes out on bcd to a
// shared BCD->segment decoder and its anode is pulled low. The last BLANK_CYC
// cycles of every slot keep all anodes off so the segment lines can settle
// without ghosting into the next digit.
//
// Display data is double-buffered. load captures din into a pending buffer;
// the pending value moves into the displayed (shadow) buffer only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Parameters
//   NDIG       number of digits scanned (>= 2), digit 0 least significant
//   SLOT_CYC   clk cycles per digit slot (>= 4)
//   BLANK_CYC  cycles at the end of each slot with all anodes off
//              (1 .. SLOT_CYC-2)
//
// Ports
//   clk      in   1       system clock, rising edge
//   rst_n    in   1       asynchronous reset, active-low
//   enable   in   1       1 = scan running, 0 = dark with counters held at 0
//   din      in   4*NDIG  new display value, nibble i = digit i
//   load     in   1       one-cycle strobe: capture din into pending buffer
//   pend     out  1       pending buffer holds data not yet displayed
//   frame    out  1       one-cycle pulse after the last slot of a frame
//   bcd      out  4       nibble of the digit being scanned
//   sseg_an  out  NDIG    anode enables, active-low, at most one bit low
//
// Configuration
//   SSEG_LZB_EN  when defined, leading zeros are blanked: a digit above
//                digit 0 stays dark in its slot if it and every more
//                significant shadow digit are zero. Timing, bcd and frame
//                are unaffected. When undefined, every digit is lit.
// ---------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [4*NDIG-1:0]   din,
    input  logic                load,
    output logic                pend,
    output logic                frame,
    output logic [3:0]          bcd,
    output logic [NDIG-1:0]     sseg_an
);

    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(SLOT_CYC - BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [4*NDIG-1:0]  shadow;
    logic [4*NDIG-1:0]  pending;

    logic               show_phase;
    logic               slot_end;
    logic               boundary;
    logic               apply;
    logic               show_lit;
    logic [3:0]         digit_nib;
    logic [NDIG-1:0]    an_onehot;

    assign show_phase = (cnt < CNT_SHOW);
    assign slot_end   = (cnt == CNT_LAST);
    assign boundary   = enable && slot_end && (idx == IDX_LAST);

    // While disabled nothing is shown, so pending data can be committed at
    // once instead of waiting for a frame boundary that will never come.
    assign apply      = pend && (boundary || !enable);

    assign digit_nib  = shadow[{idx, 2'b00} +: 4];
    assign an_onehot  = NDIG'(1) << idx;

`ifdef SSEG_LZB_EN
    // upper_nz[i] is set when any shadow digit i..NDIG-1 is non-zero, i.e.
    // digit i is not a leading zero.
    logic [NDIG-1:0] upper_nz;
    logic            acc;

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc      = 1'b0;
        upper_nz = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            acc         = acc | (|shadow[4*i +: 4]);
            upper_nz[i] = acc;
        end
    end

    assign show_lit = (idx == '0) || upper_nz[idx];
`else
    assign show_lit = 1'b1;
`endif

    // Double buffer. The shadow buffer feeds the display straight out of
    // reset, so both data buffers are reset along with the flags.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            pending <= '0;
            pend    <= 1'b0;
        end else begin
            // A load on the commit edge wins for pending; the old pending
            // value still reaches the shadow buffer on that same edge.
            if (apply) begin
                shadow <= pending;
            end
            if (load) begin
                pending <= din;
                pend    <= 1'b1;
            end else if (apply) begin
                pend    <= 1'b0;
            end
        end
    end

    // Slot/digit counters and registered display outputs. Outputs reflect
    // the cnt/idx values before the edge, one cycle behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            frame   <= 1'b0;
            bcd     <= 4'h0;
            sseg_an <= '1;
        end else begin
            frame <= boundary;
            if (!enable) begin
                cnt     <= '0;
                idx     <= '0;
                sseg_an <= '1;
            end else begin
                if (slot_end) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                // bcd is only updated in SHOW so the decoder input is stable
                // through the blanking gap.
                if (show_phase) begin
                    bcd     <= digit_nib;
                    sseg_an <= show_lit ? ~an_onehot : '1;
                end else begin
                    sseg_an <= '1;
                end
            end
        end
    end

endmodule
